// File: rtl/key_sequence_player.sv
// ============================================================================
// key_sequence_player: converts a 32-bit code to decimal and replays it as
// timed keypad presses, most-significant digit first.  Rev 1.0
// ============================================================================
`default_nettype none

module key_sequence_player #(
  parameter logic [31:0] PRESS_CYCLES  = 32'd1200000,
  parameter logic [31:0] GAP_CYCLES    = 32'd1200000,
  parameter bit          LEADING_ZEROS = 1'b0
) (
  input  logic        hwclk,
  input  logic        resetN,
  input  logic        start,
  input  logic [31:0] code,
  input  logic        abort,
  output logic [3:0]  button,
  output logic        bstate,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_SEEK    = 3'd2,
    S_PRESS   = 3'd3,
    S_GAP     = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_code;
  logic [31:0] r_timer;
  logic [39:0] r_bcd;
  logic [4:0]  r_cnt;
  logic [3:0]  r_ptr;
  logic [3:0]  r_button;
  logic        r_bstate;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_digit_count;

  logic [35:0] w_adj;
  logic [3:0]  w_msd;
  logic [3:0]  w_next_ptr;
  logic [3:0]  w_next_digit;
  logic [3:0]  w_cur_digit;

  // Top nibble never exceeds 4 for a 32-bit input, so it needs no correction.
  for (genvar gi = 0; gi < 9; gi++) begin : g_nib
    assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                         : r_bcd[gi*4 +: 4];
  end

  always_comb begin
    w_msd = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (r_bcd[i*4 +: 4] != 4'd0) w_msd = 4'(i);
    end
    if (LEADING_ZEROS) w_msd = 4'd9;
  end

  assign w_next_ptr   = r_ptr - 4'd1;
  assign w_next_digit = r_bcd[{w_next_ptr, 2'b00} +: 4];
  assign w_cur_digit  = r_bcd[{r_ptr, 2'b00} +: 4];

  always_ff @(posedge hwclk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= S_IDLE;
      r_code        <= 32'd0;
      r_timer       <= 32'd0;
      r_bcd         <= 40'd0;
      r_cnt         <= 5'd0;
      r_ptr         <= 4'd0;
      r_button      <= 4'd0;
      r_bstate      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_digit_count <= 4'd0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state  <= S_IDLE;
      r_button <= 4'd0;
      r_bstate <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_code  <= code;
            r_busy  <= 1'b1;
            r_bcd   <= 40'd0;
            r_cnt   <= 5'd0;
            r_state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_bcd  <= {r_bcd[38:36], w_adj, r_code[31]};
          r_code <= {r_code[30:0], 1'b0};
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_SEEK;
        end
        // Two cycles: first locate the leading digit, then start its press.
        S_SEEK: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd0) begin
            r_ptr         <= w_msd;
            r_digit_count <= w_msd + 4'd1;
          end else begin
            r_bstate <= 1'b1;
            r_button <= w_cur_digit;
            r_timer  <= PRESS_CYCLES - 32'd1;
            r_state  <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (r_timer == 32'd0) begin
            r_bstate <= 1'b0;
            r_button <= 4'd0;
            r_timer  <= GAP_CYCLES - 32'd1;
            r_state  <= S_GAP;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        S_GAP: begin
          if (r_timer != 32'd0) begin
            r_timer <= r_timer - 32'd1;
          end else if (r_ptr == 4'd0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_ptr    <= w_next_ptr;
            r_button <= w_next_digit;
            r_bstate <= 1'b1;
            r_timer  <= PRESS_CYCLES - 32'd1;
            r_state  <= S_PRESS;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign button      = r_button;
  assign bstate      = r_bstate;
  assign busy        = r_busy;
  assign done        = r_done;
  assign digit_count = r_digit_count;

endmodule

`default_nettype wire

// File: tb/tb_key_sequence_player.sv
// ============================================================================
// tb_key_sequence_player: table-driven and randomized checks of key replay
// timing against a digit-list model, on two parameterisations.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_sequence_player;

  localparam int P1 = 4;
  localparam int G1 = 2;
  localparam int P2 = 1;
  localparam int G2 = 1;

  logic        hwclk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] code = 32'd0;
  logic        abort = 1'b0;

  logic [3:0] btn1, dc1, btn2, dc2;
  logic       bs1, busy1, done1, bs2, busy2, done2;

  int checks = 0;
  int failures = 0;

  key_sequence_player #(.PRESS_CYCLES(32'(P1)), .GAP_CYCLES(32'(G1)), .LEADING_ZEROS(1'b0)) dut1 (
    .hwclk(hwclk), .resetN(resetN), .start(start), .code(code), .abort(abort),
    .button(btn1), .bstate(bs1), .busy(busy1), .done(done1), .digit_count(dc1)
  );

  key_sequence_player #(.PRESS_CYCLES(32'(P2)), .GAP_CYCLES(32'(G2)), .LEADING_ZEROS(1'b1)) dut2 (
    .hwclk(hwclk), .resetN(resetN), .start(start), .code(code), .abort(abort),
    .button(btn2), .bstate(bs2), .busy(busy2), .done(done2), .digit_count(dc2)
  );

  always #5 hwclk = ~hwclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] code;
    logic [39:0] bcd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
    end
  endtask

  function automatic logic [39:0] to_bcd(input logic [31:0] c);
    logic [39:0] r;
    longint unsigned v;
    r = 40'd0;
    v = longint'(c);
    for (int i = 0; i < 10; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int ndig(input logic [39:0] bcd, input bit lz);
    int n;
    if (lz) return 10;
    n = 1;
    for (int i = 0; i < 10; i++) if (bcd[i*4 +: 4] != 4'd0) n = i + 1;
    return n;
  endfunction

  // Expected {busy, done, bstate, button} in the cycle following edge E0+t.
  function automatic logic [6:0] expv(input int t, input logic [39:0] bcd, input int n,
                                      input int p, input int g, input int ab);
    int tend, k;
    logic [6:0] r;
    r = 7'd0;
    if (ab >= 0 && t >= ab) return r;
    tend = 34 + n * (p + g);
    if (t < tend) r[6] = 1'b1;
    if (t == tend) r[5] = 1'b1;
    if (t >= 34 && t < tend) begin
      k = (t - 34) / (p + g);
      if ((t - 34) % (p + g) < p) begin
        r[4]   = 1'b1;
        r[3:0] = bcd[(n - 1 - k)*4 +: 4];
      end
    end
    return r;
  endfunction

  task automatic run_play(input logic [39:0] bcd, input logic [31:0] c, input int rep_at,
                          input logic [31:0] rep_code, input int ab_at, input bit ab_e0);
    int n1, n2, tmax;
    n1 = ndig(bcd, 1'b0);
    n2 = ndig(bcd, 1'b1);
    tmax = (ab_at >= 0) ? ab_at + 2 : ((34 + n1*(P1+G1) > 34 + n2*(P2+G2)) ?
                                       34 + n1*(P1+G1) : 34 + n2*(P2+G2)) + 1;
    @(negedge hwclk);
    start = 1'b1;
    code  = c;
    abort = ab_e0;
    for (int t = 0; t <= tmax; t++) begin
      @(negedge hwclk);
      chk("dut1_out", t, 32'({busy1, done1, bs1, btn1}), 32'(expv(t, bcd, n1, P1, G1, ab_at)));
      chk("dut2_out", t, 32'({busy2, done2, bs2, btn2}), 32'(expv(t, bcd, n2, P2, G2, ab_at)));
      if (t >= 33 && (ab_at < 0 || t < ab_at)) begin
        chk("dut1_count", t, 32'(dc1), 32'(n1));
        chk("dut2_count", t, 32'(dc2), 32'(n2));
      end
      start = (t + 1 == rep_at);
      if (t + 1 == rep_at) code = rep_code;
      abort = (t + 1 == ab_at);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic reset_mid(input int at, input logic exp_bs1, input logic exp_bs2);
    @(negedge hwclk);
    start = 1'b1;
    code  = 32'd555116;
    for (int t = 0; t <= at; t++) begin
      @(negedge hwclk);
      start = 1'b0;
    end
    chk("pre_reset_bs1", at, 32'(bs1), 32'(exp_bs1));
    chk("pre_reset_bs2", at, 32'(bs2), 32'(exp_bs2));
    #2 resetN = 1'b0;
    #1;
    chk("async_reset_dut1", at, 32'({busy1, done1, bs1, btn1, dc1}), 32'd0);
    chk("async_reset_dut2", at, 32'({busy2, done2, bs2, btn2, dc2}), 32'd0);
    @(negedge hwclk);
    resetN = 1'b1;
    code = 32'd777;
    for (int t = 0; t < 5; t++) begin
      @(negedge hwclk);
      chk("stale_idle", t, 32'({busy1, bs1, busy2, bs2}), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{32'd555116,     40'h0000555116};
    vecs[1] = '{32'd0,          40'h0000000000};
    vecs[2] = '{32'd4294967295, 40'h4294967295};
    vecs[3] = '{32'd1000,       40'h0000001000};
    vecs[4] = '{32'd9,          40'h0000000009};
    vecs[5] = '{32'd10,         40'h0000000010};

    repeat (3) @(negedge hwclk);
    chk("reset_dut1", 0, 32'({busy1, done1, bs1, btn1, dc1}), 32'd0);
    chk("reset_dut2", 0, 32'({busy2, done2, bs2, btn2, dc2}), 32'd0);
    resetN = 1'b1;
    @(negedge hwclk);

    for (int i = 0; i < 6; i++) run_play(vecs[i].bcd, vecs[i].code, -1, 32'd0, -1, 1'b0);

    // Re-pulsed start while busy is ignored; the next start picks up the new code.
    run_play(40'h0000555116, 32'd555116, 40, 32'd666666, -1, 1'b0);
    run_play(40'h0000666666, 32'd666666, -1, 32'd0, -1, 1'b0);

    // Abort during dut1's third press, then a full replay.
    run_play(40'h0000555116, 32'd555116, -1, 32'd0, 47, 1'b0);
    run_play(40'h0000555116, 32'd555116, -1, 32'd0, -1, 1'b0);

    // Abort together with start in IDLE: start wins.
    run_play(40'h0000001234, 32'd1234, -1, 32'd0, -1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] rc;
      rc = $urandom >> $urandom_range(0, 31);
      run_play(to_bcd(rc), rc, -1, 32'd0, -1, 1'b0);
    end

    reset_mid(35, 1'b1, 1'b0);
    reset_mid(38, 1'b0, 1'b1);

    run_play(40'h0000000042, 32'd42, -1, 32'd0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
